calc_controller: RTL and testbench
==================================

Name: calc_controller

Overview:
- Keypad-driven sequencer for the calculator datapath.
- Accepts decoded key events and drives the 3-digit input register's num/numPressed/erase strobes.
- Latches operands from the register's binary value, launches the shared ALU, and selects what the display shows.
- Sits between the keypad decoder and the input register / ALU / display mux.

Parameters:
MAX_DIGITS, 3, digits accepted per operand; further digit keys are ignored.
ALU_TIMEOUT, 255, cycles to wait for alu_done before entering ERROR.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle key event strobe; sampled only when key_ready=1
key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '=', 14 'C', 15 no-op
key_ready  out  1  controller can accept a key this cycle
ir_num  out  4  digit to input register, valid with ir_num_pressed
ir_num_pressed  out  1  one-cycle digit strobe to input register
ir_erase  out  1  one-cycle clear strobe to input register
ir_value  in  16  binary value held by input register
alu_start  out  1  one-cycle start strobe
alu_op  out  2  0 add, 1 sub, 2 mul; held from start until done
alu_a  out  16  operand A, held stable while busy
alu_b  out  16  operand B, held stable while busy
alu_done  in  1  one-cycle completion strobe
alu_result  in  16  valid with alu_done
alu_overflow  in  1  valid with alu_done
disp_value  out  16  value to display
error  out  1  high in ERROR state

Behaviour:
- Reset (async, reset=0): state ENTRY_A; opA=opB=0; digit count 0; all strobes 0; alu_op 0; disp_value 0; error 0; key_ready 1.
- States: ENTRY_A, OP_WAIT, ENTRY_B, CALC, RESULT, ERROR.
- Strobe timing: every ir_* and alu_start pulse is registered, exactly 1 cycle wide, and asserted the cycle after the accepting key_valid.
- key_ready is 0:
  - in the cycle a strobe is high and the cycle after it, so ir_value can settle;
  - throughout CALC, except that 'C' is still accepted in CALC.
- Keys with key_valid while key_ready=0 are dropped silently.
- ENTRY_A:
  - Digit with count<MAX_DIGITS: pulse ir_num_pressed, count++.
  - Operator: opA<=ir_value; latch op; go OP_WAIT.
  - '=' and no-op: ignored.
- OP_WAIT:
  - Operator: replaces latched op.
  - Digit: ir_erase, then ir_num_pressed on the next cycle; count=1; go ENTRY_B. key_ready stays low for 3 cycles in total.
- ENTRY_B:
  - Digit: as in ENTRY_A.
  - '=': opB<=ir_value; pulse alu_start; go CALC.
  - Operator: ignored.
- CALC:
  - Wait for alu_done, counting cycles.
  - alu_done with overflow=0: result<=alu_result; go RESULT.
  - alu_done with overflow=1: go ERROR.
  - Count reaches ALU_TIMEOUT without alu_done: go ERROR.
- RESULT:
  - Operator: opA<=result; latch op; go OP_WAIT (chaining).
  - Digit: ir_erase, then digit strobe; count=1; go ENTRY_A.
  - '=': ignored.
- ERROR: error=1; only 'C' is accepted.
- 'C' in any state:
  - pulse ir_erase; go ENTRY_A; count=0; opA=opB=0; error=0;
  - an alu_done arriving later for an aborted CALC is ignored.
- Digit with count=MAX_DIGITS: no strobe, state unchanged, key_ready unaffected.
- disp_value (registered, 1-cycle lag):
  - ENTRY_A/ENTRY_B: ir_value
  - OP_WAIT: opA
  - CALC: opB
  - RESULT: result
  - ERROR: 16'hFFFF
- Sub wraps modulo 2^16. Overflow detection is the ALU's responsibility; the controller only reacts to alu_overflow.
- Simultaneous key_valid and alu_done in CALC: 'C' wins; any other key is dropped.

Test Plan:
- Reset, then digits 5,9,8 with keys 4 cycles apart (input register model: value=598) -> three ir_num_pressed pulses with ir_num 5,9,8; disp_value=598; error=0.
- Keys 1,2,'+',3,'=' with the ALU model returning 15 after 4 cycles -> alu_start once, alu_a=12, alu_b=3, alu_op=0; ir_erase pulses before the digit 3 strobe; disp_value=15 in RESULT.
- Digits 1,2,3,4 -> only 3 strobes; ir_value=123. Key_valid asserted 1 cycle after a strobe -> dropped, no strobe.
- From RESULT=15: '*', 2, '=' with the model returning 30 -> alu_a=15, alu_b=2, alu_op=2; disp_value=30.
- ALU model asserts alu_overflow, or never asserts alu_done for 255 cycles -> error=1 and disp_value=FFFF; digits ignored; 'C' -> ir_erase pulse, error=0, state ENTRY_A.
- 'C' during CALC, then a late alu_done -> state stays ENTRY_A; disp_value does not take alu_result.
- Assert reset mid-CALC -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/calc_controller.sv
// Keypad sequencer for the calculator: drives the input register strobes,
// latches operands, launches the shared ALU and selects the display source.
module calc_controller #(
  parameter int MAX_DIGITS  = 3,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [3:0]  ir_num,
  output logic        ir_num_pressed,
  output logic        ir_erase,
  input  logic [15:0] ir_value,
  output logic        alu_start,
  output logic [1:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_overflow,
  output logic [15:0] disp_value,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_ENTRY_A, ST_OP_WAIT, ST_ENTRY_B, ST_CALC, ST_RESULT, ST_ERROR
  } state_e;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT      = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ALU_TIMEOUT - 1);

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_EQ  = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    hold_q, hold_d;
  logic [15:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d, disp_q, disp_d;
  logic [1:0]    op_q, op_d;
  logic [3:0]    num_q, num_d;
  logic          pend_q, pend_d;
  logic          num_pressed_q, num_pressed_d;
  logic          erase_q, erase_d;
  logic          start_q, start_d;

  logic is_digit, is_op, accept;

  function automatic logic [1:0] op_of(input logic [3:0] k);
    case (k)
      KEY_SUB: op_of = 2'd1;
      KEY_MUL: op_of = 2'd2;
      default: op_of = 2'd0;
    endcase
  endfunction

  assign is_digit  = (key_code <= 4'd9);
  assign is_op     = (key_code == KEY_ADD) || (key_code == KEY_SUB) || (key_code == KEY_MUL);
  // hold_q keeps keys off while ir_value settles after a strobe.
  assign key_ready = (hold_q == 2'd0) && (state_q != ST_CALC);
  assign accept    = key_valid && (key_ready || (state_q == ST_CALC && key_code == KEY_CLR));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d       = state_q;
    count_d       = count_q;
    timer_d       = timer_q;
    hold_d        = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    opa_d         = opa_q;
    opb_d         = opb_q;
    result_d      = result_q;
    op_d          = op_q;
    num_d         = num_q;
    pend_d        = 1'b0;
    num_pressed_d = pend_q;
    erase_d       = 1'b0;
    start_d       = 1'b0;

    if (accept && key_code == KEY_CLR) begin
      erase_d = 1'b1;
      hold_d  = 2'd2;
      state_d = ST_ENTRY_A;
      count_d = '0;
      opa_d   = '0;
      opb_d   = '0;
    end else begin
      unique case (state_q)
        ST_ENTRY_A, ST_ENTRY_B: begin
          if (accept && is_digit) begin
            if (count_q < MAX_CNT) begin
              num_d         = key_code;
              num_pressed_d = 1'b1;
              count_d       = count_q + 1'b1;
              hold_d        = 2'd2;
            end
          end else if (accept && is_op && state_q == ST_ENTRY_A) begin
            opa_d   = ir_value;
            op_d    = op_of(key_code);
            state_d = ST_OP_WAIT;
          end else if (accept && key_code == KEY_EQ && state_q == ST_ENTRY_B) begin
            opb_d   = ir_value;
            start_d = 1'b1;
            hold_d  = 2'd2;
            timer_d = '0;
            state_d = ST_CALC;
          end
        end
        ST_OP_WAIT, ST_RESULT: begin
          if (accept && is_op) begin
            if (state_q == ST_RESULT) opa_d = result_q;
            op_d    = op_of(key_code);
            state_d = ST_OP_WAIT;
          end else if (accept && is_digit) begin
            // Clear the register first; the digit strobe follows one cycle later.
            erase_d = 1'b1;
            pend_d  = 1'b1;
            num_d   = key_code;
            count_d = CW'(1);
            hold_d  = 2'd3;
            state_d = (state_q == ST_OP_WAIT) ? ST_ENTRY_B : ST_ENTRY_A;
          end
        end
        ST_CALC: begin
          if (alu_done) begin
            if (alu_overflow) begin
              state_d = ST_ERROR;
            end else begin
              result_d = alu_result;
              state_d  = ST_RESULT;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = ST_ERROR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_ERROR: ;
        default: state_d = ST_ENTRY_A;
      endcase
    end

    unique case (state_q)
      ST_OP_WAIT: disp_d = opa_q;
      ST_CALC:    disp_d = opb_q;
      ST_RESULT:  disp_d = result_q;
      ST_ERROR:   disp_d = 16'hFFFF;
      default:    disp_d = ir_value;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ENTRY_A;
      count_q       <= '0;
      timer_q       <= '0;
      hold_q        <= 2'd0;
      opa_q         <= '0;
      opb_q         <= '0;
      result_q      <= '0;
      op_q          <= 2'd0;
      num_q         <= 4'd0;
      pend_q        <= 1'b0;
      num_pressed_q <= 1'b0;
      erase_q       <= 1'b0;
      start_q       <= 1'b0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      hold_q        <= hold_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      result_q      <= result_d;
      op_q          <= op_d;
      num_q         <= num_d;
      pend_q        <= pend_d;
      num_pressed_q <= num_pressed_d;
      erase_q       <= erase_d;
      start_q       <= start_d;
      disp_q        <= disp_d;
    end
  end

  assign ir_num         = num_q;
  assign ir_num_pressed = num_pressed_q;
  assign ir_erase       = erase_q;
  assign alu_start      = start_q;
  assign alu_op         = op_q;
  assign alu_a          = opa_q;
  assign alu_b          = opb_q;
  assign disp_value     = disp_q;
  assign error          = (state_q == ST_ERROR);

endmodule

// File: tb/tb_calc_controller.sv
// Bench for calc_controller: input-register and ALU models, strobe scoreboard,
// a key table for the main flow and hand sequences for error/abort/reset cases.
module tb_calc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [3:0]  ir_num;
  logic        ir_num_pressed, ir_erase;
  logic [15:0] ir_value;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_overflow;
  logic [15:0] disp_value;
  logic        error;

  calc_controller dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .ir_num(ir_num), .ir_num_pressed(ir_num_pressed),
    .ir_erase(ir_erase), .ir_value(ir_value), .alu_start(alu_start),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_done(alu_done),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .disp_value(disp_value), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Input register model: 3-digit decimal accumulator.
  always @(posedge clk or negedge reset) begin
    if (!reset)              ir_value <= 16'd0;
    else if (ir_erase)       ir_value <= 16'd0;
    else if (ir_num_pressed) ir_value <= 16'(ir_value * 16'd10 + {12'd0, ir_num});
  end

  // ALU model with configurable latency, overflow and hang.
  int          alu_lat  = 4;
  logic        alu_ovf  = 1'b0;
  logic        alu_hang = 1'b0;
  logic        m_busy;
  int          m_cnt;
  logic [1:0]  m_op;
  logic [15:0] m_a, m_b;

  function automatic logic [15:0] alu_f(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'd0:    alu_f = a + b;
      2'd1:    alu_f = a - b;
      default: alu_f = 16'(a * b);
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_done <= 1'b0; alu_result <= 16'd0; alu_overflow <= 1'b0;
      m_busy <= 1'b0; m_cnt <= 0; m_op <= 2'd0; m_a <= 16'd0; m_b <= 16'd0;
    end else begin
      alu_done     <= 1'b0;
      alu_overflow <= 1'b0;
      if (alu_start) begin
        m_busy <= 1'b1; m_cnt <= alu_lat; m_op <= alu_op; m_a <= alu_a; m_b <= alu_b;
      end else if (m_busy && !alu_hang) begin
        if (m_cnt <= 1) begin
          alu_done     <= 1'b1;
          alu_result   <= alu_f(m_op, m_a, m_b);
          alu_overflow <= alu_ovf;
          m_busy       <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Scoreboard of expected strobes: kind 0 digit, 1 erase, 2 alu start.
  typedef struct {
    logic [1:0]  kind;
    logic [3:0]  num;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } sb_t;
  sb_t sb[$];

  task automatic sb_match(input logic [1:0] kind, input logic [3:0] num,
                          input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe: got strobe kind %0d, expected no strobe", kind);
    end else begin
      e = sb.pop_front();
      check("strobe_kind", 32'(kind), 32'(e.kind));
      if (kind == 2'd0 && e.kind == 2'd0) check("strobe_num", 32'(num), 32'(e.num));
      if (kind == 2'd2 && e.kind == 2'd2) begin
        check("alu_op", 32'(op), 32'(e.op));
        check("alu_a", 32'(a), 32'(e.a));
        check("alu_b", 32'(b), 32'(e.b));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (ir_erase)       sb_match(2'd1, 4'd0, 2'd0, 16'd0, 16'd0);
      if (ir_num_pressed) sb_match(2'd0, ir_num, 2'd0, 16'd0, 16'd0);
      if (alu_start)      sb_match(2'd2, 4'd0, alu_op, alu_a, alu_b);
    end
  end

  typedef enum logic [2:0] {EX_NONE, EX_NUM, EX_ERASE, EX_ERASE_NUM, EX_START} exp_e;

  task automatic expect_strobes(input exp_e k, input logic [3:0] key, input logic [1:0] op,
                                input logic [15:0] a, input logic [15:0] b);
    case (k)
      EX_NUM:       sb.push_back(sb_t'{2'd0, key, 2'd0, 16'd0, 16'd0});
      EX_ERASE:     sb.push_back(sb_t'{2'd1, 4'd0, 2'd0, 16'd0, 16'd0});
      EX_ERASE_NUM: begin
        sb.push_back(sb_t'{2'd1, 4'd0, 2'd0, 16'd0, 16'd0});
        sb.push_back(sb_t'{2'd0, key, 2'd0, 16'd0, 16'd0});
      end
      EX_START:     sb.push_back(sb_t'{2'd2, 4'd0, op, a, b});
      default: ;
    endcase
  endtask

  task automatic drive_key(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd15;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) begin
      checks++;
      errors++;
      $display("FAIL key_ready_timeout: key_ready still %0d after %0d cycles, expected 1", key_ready, n);
    end
  endtask

  task automatic press(input logic [3:0] code, input exp_e k, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    wait_ready();
    expect_strobes(k, code, op, a, b);
    drive_key(code);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  key;
    exp_e        kind;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] disp;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  initial begin
    int cyc;

    vecs.push_back(vec_t'{4'd5,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd5,     1'b0});
    vecs.push_back(vec_t'{4'd9,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd59,    1'b0});
    vecs.push_back(vec_t'{4'd8,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd598,   1'b0});
    vecs.push_back(vec_t'{4'd4,  EX_NONE,      2'd0, 16'd0,  16'd0,   16'd598,   1'b0});
    vecs.push_back(vec_t'{4'd14, EX_ERASE,     2'd0, 16'd0,  16'd0,   16'd0,     1'b0});
    vecs.push_back(vec_t'{4'd13, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd0,     1'b0});
    vecs.push_back(vec_t'{4'd1,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd1,     1'b0});
    vecs.push_back(vec_t'{4'd2,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd12,    1'b0});
    vecs.push_back(vec_t'{4'd10, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd12,    1'b0});
    vecs.push_back(vec_t'{4'd11, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd12,    1'b0});
    vecs.push_back(vec_t'{4'd10, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd12,    1'b0});
    vecs.push_back(vec_t'{4'd3,  EX_ERASE_NUM, 2'd0, 16'd0,  16'd0,   16'd3,     1'b0});
    vecs.push_back(vec_t'{4'd12, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd3,     1'b0});
    vecs.push_back(vec_t'{4'd13, EX_START,     2'd0, 16'd12, 16'd3,   16'd15,    1'b0});
    vecs.push_back(vec_t'{4'd13, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd15,    1'b0});
    vecs.push_back(vec_t'{4'd12, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd15,    1'b0});
    vecs.push_back(vec_t'{4'd2,  EX_ERASE_NUM, 2'd0, 16'd0,  16'd0,   16'd2,     1'b0});
    vecs.push_back(vec_t'{4'd13, EX_START,     2'd2, 16'd15, 16'd2,   16'd30,    1'b0});
    vecs.push_back(vec_t'{4'd11, EX_NONE,      2'd0, 16'd0,  16'd0,   16'd30,    1'b0});
    vecs.push_back(vec_t'{4'd9,  EX_ERASE_NUM, 2'd0, 16'd0,  16'd0,   16'd9,     1'b0});
    vecs.push_back(vec_t'{4'd9,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd99,    1'b0});
    vecs.push_back(vec_t'{4'd9,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd999,   1'b0});
    vecs.push_back(vec_t'{4'd13, EX_START,     2'd1, 16'd30, 16'd999, 16'd64567, 1'b0});
    vecs.push_back(vec_t'{4'd7,  EX_ERASE_NUM, 2'd0, 16'd0,  16'd0,   16'd7,     1'b0});
    vecs.push_back(vec_t'{4'd1,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd71,    1'b0});
    vecs.push_back(vec_t'{4'd2,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd712,   1'b0});
    vecs.push_back(vec_t'{4'd3,  EX_NONE,      2'd0, 16'd0,  16'd0,   16'd712,   1'b0});
    vecs.push_back(vec_t'{4'd14, EX_ERASE,     2'd0, 16'd0,  16'd0,   16'd0,     1'b0});
    vecs.push_back(vec_t'{4'd1,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd1,     1'b0});
    vecs.push_back(vec_t'{4'd2,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd12,    1'b0});
    vecs.push_back(vec_t'{4'd3,  EX_NUM,       2'd0, 16'd0,  16'd0,   16'd123,   1'b0});
    vecs.push_back(vec_t'{4'd4,  EX_NONE,      2'd0, 16'd0,  16'd0,   16'd123,   1'b0});
    vecs.push_back(vec_t'{4'd14, EX_ERASE,     2'd0, 16'd0,  16'd0,   16'd0,     1'b0});

    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd15;
    settle(2);
    check("rst_key_ready", 32'(key_ready), 32'd1);
    check("rst_strobes", {29'd0, ir_num_pressed, ir_erase, alu_start}, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    check("rst_disp", 32'(disp_value), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    settle(2);

    for (int i = 0; i < vecs.size(); i++) begin
      press(vecs[i].key, vecs[i].kind, vecs[i].op, vecs[i].a, vecs[i].b);
      settle(12);
      check($sformatf("vec%0d_disp", i), 32'(disp_value), 32'(vecs[i].disp));
      check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
    end

    // Key offered while a strobe is still settling must be dropped.
    press(4'd1, EX_NUM, 2'd0, 16'd0, 16'd0);
    check("busy_key_ready", 32'(key_ready), 32'd0);
    drive_key(4'd5);
    settle(6);
    check("dropped_key_disp", 32'(disp_value), 32'd1);
    press(4'd14, EX_ERASE, 2'd0, 16'd0, 16'd0);
    settle(4);

    // ALU overflow -> ERROR, digits ignored, 'C' recovers.
    alu_ovf = 1'b1;
    press(4'd2, EX_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd10, EX_NONE, 2'd0, 16'd0, 16'd0);
    press(4'd3, EX_ERASE_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd13, EX_START, 2'd0, 16'd2, 16'd3);
    settle(12);
    alu_ovf = 1'b0;
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_disp", 32'(disp_value), 32'hFFFF);
    press(4'd4, EX_NONE, 2'd0, 16'd0, 16'd0);
    settle(6);
    check("err_digit_ignored", 32'(error), 32'd1);
    press(4'd14, EX_ERASE, 2'd0, 16'd0, 16'd0);
    settle(4);
    check("clr_error", 32'(error), 32'd0);
    check("clr_disp", 32'(disp_value), 32'd0);

    // ALU never answers -> timeout into ERROR after about ALU_TIMEOUT cycles.
    alu_hang = 1'b1;
    press(4'd1, EX_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd10, EX_NONE, 2'd0, 16'd0, 16'd0);
    press(4'd1, EX_ERASE_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd13, EX_START, 2'd0, 16'd1, 16'd1);
    cyc = 0;
    while (!error && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_window", 32'(cyc >= 250 && cyc <= 260), 32'd1);
    settle(2);
    check("timeout_disp", 32'(disp_value), 32'hFFFF);
    alu_hang = 1'b0;
    press(4'd14, EX_ERASE, 2'd0, 16'd0, 16'd0);
    settle(4);
    check("timeout_clr_error", 32'(error), 32'd0);

    // 'C' aborts CALC; the late alu_done must be ignored.
    alu_lat = 20;
    press(4'd4, EX_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd10, EX_NONE, 2'd0, 16'd0, 16'd0);
    press(4'd5, EX_ERASE_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd13, EX_START, 2'd0, 16'd4, 16'd5);
    settle(3);
    check("calc_key_ready", 32'(key_ready), 32'd0);
    expect_strobes(EX_ERASE, 4'd14, 2'd0, 16'd0, 16'd0);
    drive_key(4'd14);
    settle(30);
    check("abort_error", 32'(error), 32'd0);
    check("abort_disp", 32'(disp_value), 32'd0);
    press(4'd6, EX_NUM, 2'd0, 16'd0, 16'd0);
    settle(6);
    check("abort_entry_a_disp", 32'(disp_value), 32'd6);
    press(4'd14, EX_ERASE, 2'd0, 16'd0, 16'd0);
    settle(4);

    // Asynchronous reset in the middle of CALC.
    press(4'd9, EX_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd12, EX_NONE, 2'd0, 16'd0, 16'd0);
    press(4'd9, EX_ERASE_NUM, 2'd0, 16'd0, 16'd0);
    press(4'd13, EX_START, 2'd2, 16'd9, 16'd9);
    settle(3);
    #2 reset = 1'b0;
    #1;
    check("arst_key_ready", 32'(key_ready), 32'd1);
    check("arst_alu_op", 32'(alu_op), 32'd0);
    check("arst_alu_ab", {alu_a, alu_b}, 32'd0);
    check("arst_disp", 32'(disp_value), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_strobes", {29'd0, ir_num_pressed, ir_erase, alu_start}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    settle(30);
    check("arst_after_disp", 32'(disp_value), 32'd0);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
